// File: rtl/fpdiv_param_pkg.sv
// fpdiv_pkg: shared types and helpers for the parametrised FP divider.
//   - field extractors for sign / exponent / fraction of a packed operand
//   - operand class and FSM state enums
//   - flag bit positions inside the 5-bit flags word
//   - canonical quiet-NaN builder
// Helpers work on a MAX_W-wide container so one set of functions serves every
// EXP_W/MAN_W combination; callers zero-extend in and size-cast the result.
package fpdiv_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    C_ZERO,
    C_NORM,
    C_INF,
    C_NAN
  } op_class_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_NORM,
    S_OUT
  } state_t;

  // flags = {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int unsigned FLAG_NX  = 0;
  localparam int unsigned FLAG_UF  = 1;
  localparam int unsigned FLAG_OF  = 2;
  localparam int unsigned FLAG_DZ  = 3;
  localparam int unsigned FLAG_INV = 4;

  function automatic logic get_sign(input logic [MAX_W-1:0] v, input int unsigned w);
    return v[w-1];
  endfunction

  function automatic logic [MAX_W-1:0] get_exp(input logic [MAX_W-1:0] v,
                                               input int unsigned exp_w,
                                               input int unsigned man_w);
    return (v >> man_w) & ~({MAX_W{1'b1}} << exp_w);
  endfunction

  function automatic logic [MAX_W-1:0] get_frac(input logic [MAX_W-1:0] v,
                                                input int unsigned man_w);
    return v & ~({MAX_W{1'b1}} << man_w);
  endfunction

  // Subnormals (exp==0, frac!=0) are flushed to zero.
  function automatic op_class_t classify(input logic exp_zero,
                                         input logic exp_ones,
                                         input logic frac_nz);
    if (exp_zero)      return C_ZERO;
    else if (exp_ones) return frac_nz ? C_NAN : C_INF;
    else               return C_NORM;
  endfunction

  // Sign 0, exponent all-ones, fraction MSB set, rest clear.
  function automatic logic [MAX_W-1:0] canon_nan(input int unsigned exp_w,
                                                 input int unsigned man_w);
    return (~({MAX_W{1'b1}} << exp_w) << man_w) | (MAX_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fpdiv_param_mant_div_iter.sv
// mant_div_iter: restoring fractional divider, one quotient bit per cycle.
//   clk, rst   : clock, asynchronous active-low reset
//   start      : load a/b (takes priority over iteration)
//   a, b       : N-bit mantissas with hidden bit, both in [1,2)
//   done       : high during the final iteration cycle
//   q          : N+2 quotient bits, q[N+1] has weight 2^0
//   rem_nz     : final partial remainder is non-zero
module mant_div_iter #(
  parameter  int unsigned N  = 8,
  localparam int unsigned QW = N + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          done,
  output logic [QW-1:0] q,
  output logic          rem_nz
);
  import fpdiv_pkg::*;

  localparam int unsigned CW = $clog2(QW + 1);

  logic [N:0]    rem;
  logic [N-1:0]  div;
  logic [CW-1:0] cnt;
  logic [N:0]    div_x;
  logic [N:0]    diff;
  logic          ge;

  assign div_x  = {1'b0, div};
  assign ge     = rem >= div_x;
  assign diff   = rem - div_x;
  assign done   = (cnt == CW'(1));
  assign rem_nz = |rem;

  // a < 2b, so after a subtract rem < b and the shifted value still fits N+1 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= '0;
      div <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= {1'b0, a};
      div <= b;
      q   <= '0;
      cnt <= CW'(QW);
    end else if (cnt != '0) begin
      q   <= {q[QW-2:0], ge};
      rem <= (ge ? diff : rem) << 1;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/fpdiv_param.sv
// fpdiv_param: parametrised floating-point divider, round-to-nearest-even,
// one operation in flight, valid/ready on both sides.
//   clk, rst            : clock, asynchronous active-low reset
//   x1, x2              : dividend, divisor (W = 1+EXP_W+MAN_W)
//   in_valid, in_ready  : operand handshake (in_ready only in IDLE)
//   y, flags            : quotient and {invalid, div_by_zero, overflow,
//                         underflow, inexact}, held while out_valid
//   out_valid, out_ready: result handshake
module fpdiv_param
  import fpdiv_pkg::*;
#(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 7,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic [4:0]   flags,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned N    = MAN_W + 1;
  localparam int unsigned QW   = MAN_W + 3;
  localparam int unsigned EW2  = EXP_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

  typedef logic signed [EW2-1:0] sexp_t;

  localparam sexp_t        E_BIAS = sexp_t'(BIAS);
  localparam sexp_t        E_MAX  = sexp_t'((1 << EXP_W) - 1);
  localparam sexp_t        E_ONE  = sexp_t'(1);
  localparam sexp_t        E_ZERO = '0;
  localparam logic [W-1:0] NAN_Y  = W'(canon_nan(EXP_W, MAN_W));

  state_t          state, state_n;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  op_class_t       cls_a, cls_b;
  logic            accept;

  logic            sign_r;
  op_class_t       cls_a_r, cls_b_r;
  sexp_t           exp_r;

  logic [QW-1:0]   q;
  logic            rem_nz;
  logic            div_done;

  logic [MAN_W-1:0] frac_n, frac_r;
  logic            guard, sticky, inc, carry;
  sexp_t           e_n;
  logic [W-1:0]    y_n;
  logic [4:0]      flags_n;
  logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea = EXP_W'(get_exp(MAX_W'(x1), EXP_W, MAN_W));
  assign eb = EXP_W'(get_exp(MAX_W'(x2), EXP_W, MAN_W));
  assign fa = MAN_W'(get_frac(MAX_W'(x1), MAN_W));
  assign fb = MAN_W'(get_frac(MAX_W'(x2), MAN_W));

  assign cls_a = classify(ea == '0, ea == '1, fa != '0);
  assign cls_b = classify(eb == '0, eb == '1, fb != '0);

  assign accept    = in_valid && (state == S_IDLE);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);

  // Loaded on the accept edge straight from the operand ports, so the DIV
  // state spends exactly QW cycles iterating; special cases still run it.
  mant_div_iter #(.N(N)) u_div (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .a      ({1'b1, fa}),
    .b      ({1'b1, fb}),
    .done   (div_done),
    .q      (q),
    .rem_nz (rem_nz)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (in_valid)  state_n = S_DIV;
      S_DIV:   if (div_done)  state_n = S_NORM;
      S_NORM:                 state_n = S_OUT;
      S_OUT:   if (out_ready) state_n = S_IDLE;
      default:                state_n = S_IDLE;
    endcase
  end

  assign a_nan  = (cls_a_r == C_NAN);
  assign b_nan  = (cls_b_r == C_NAN);
  assign a_inf  = (cls_a_r == C_INF);
  assign b_inf  = (cls_b_r == C_INF);
  assign a_zero = (cls_a_r == C_ZERO);
  assign b_zero = (cls_b_r == C_ZERO);

  // Normalise, round to nearest even, range check, then special-case override.
  always_comb begin
    frac_n = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    e_n    = exp_r;
    if (q[QW-1]) begin
      frac_n = q[QW-2:2];
      guard  = q[1];
      sticky = q[0] | rem_nz;
    end else begin
      frac_n = q[QW-3:1];
      guard  = q[0];
      sticky = rem_nz;
      e_n    = exp_r - E_ONE;
    end
    inc = guard & (sticky | frac_n[0]);
    {carry, frac_r} = {1'b0, frac_n} + {{MAN_W{1'b0}}, inc};
    if (carry) e_n = e_n + E_ONE;

    y_n              = {sign_r, e_n[EXP_W-1:0], frac_r};
    flags_n          = '0;
    flags_n[FLAG_NX] = guard | sticky;
    if (e_n >= E_MAX) begin
      y_n              = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_n[FLAG_OF] = 1'b1;
      flags_n[FLAG_NX] = 1'b1;
    end else if (e_n <= E_ZERO) begin
      y_n              = {sign_r, {(W-1){1'b0}}};
      flags_n[FLAG_UF] = 1'b1;
      flags_n[FLAG_NX] = 1'b1;
    end

    if (a_nan || b_nan) begin
      y_n     = NAN_Y;
      flags_n = '0;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      y_n               = NAN_Y;
      flags_n           = '0;
      flags_n[FLAG_INV] = 1'b1;
    end else if (a_inf) begin
      y_n     = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_n = '0;
    end else if (b_zero) begin
      y_n              = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_n          = '0;
      flags_n[FLAG_DZ] = 1'b1;
    end else if (a_zero || b_inf) begin
      y_n     = {sign_r, {(W-1){1'b0}}};
      flags_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      sign_r  <= 1'b0;
      cls_a_r <= C_ZERO;
      cls_b_r <= C_ZERO;
      exp_r   <= '0;
      y       <= '0;
      flags   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        sign_r  <= get_sign(MAX_W'(x1), W) ^ get_sign(MAX_W'(x2), W);
        cls_a_r <= cls_a;
        cls_b_r <= cls_b;
        exp_r   <= sexp_t'({2'b00, ea}) - sexp_t'({2'b00, eb}) + E_BIAS;
      end
      if (state == S_NORM) begin
        y     <= y_n;
        flags <= flags_n;
      end
    end
  end

endmodule

// File: tb/tb_fpdiv_param.sv
// Scoreboard bench for fpdiv_param at EXP_W=8, MAN_W=7.
module tb_fpdiv_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x1 = '0;
  logic [15:0] x2 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] y;
  logic [4:0]  flags;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned last_acc = 0;
  bit          lat_seen = 0;

  typedef struct {
    logic [15:0] y;
    logic [4:0]  f;
    int unsigned acc;
    string       tag;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ey;
    logic [4:0]  ef;
  } vec_t;

  vec_t vecs[14] = '{
    '{16'h40C0, 16'h4000, 16'h4040, 5'h00},  // 6/2
    '{16'h3F80, 16'h4040, 16'h3EAB, 5'h01},  // 1/3, rounds up
    '{16'h3F80, 16'h0000, 16'h7F80, 5'h08},  // x/0
    '{16'h0000, 16'h0000, 16'h7FC0, 5'h10},  // 0/0
    '{16'h7FC1, 16'h3F80, 16'h7FC0, 5'h00},  // NaN in
    '{16'hBF80, 16'h7F80, 16'h8000, 5'h00},  // -1/Inf
    '{16'h7F00, 16'h3E80, 16'h7F80, 5'h05},  // overflow
    '{16'h0080, 16'h4000, 16'h0000, 5'h03},  // underflow
    '{16'hC0C0, 16'h4000, 16'hC040, 5'h00},  // -6/2
    '{16'h7F80, 16'h7F80, 16'h7FC0, 5'h10},  // Inf/Inf
    '{16'h7F80, 16'h0000, 16'h7F80, 5'h00},  // Inf/0
    '{16'h8000, 16'h3F80, 16'h8000, 5'h00},  // -0/1
    '{16'h0001, 16'h3F80, 16'h0000, 5'h00},  // subnormal flushed
    '{16'h3F80, 16'h3F81, 16'h3F7E, 5'h01}   // quotient < 1, round down
  };

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpdiv_param #(.EXP_W(8), .MAN_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .x1        (x1),
    .x2        (x2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one operation; acc is the cycle in which in_valid&in_ready is seen.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ey, input logic [4:0] ef,
                      input bit track, input string tag);
    int unsigned waitc = 0;
    int unsigned acc;
    exp_t e;
    @(negedge clk);
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_acc = acc;
    if (track) begin
      e.y = ey; e.f = ef; e.acc = acc; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int unsigned c = 0;
    while ((sb.size() != 0 || out_valid) && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      lat_seen = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        if (out_ready) check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        if (!lat_seen) begin
          check({sb[0].tag, "_lat"}, cyc - sb[0].acc, 32'd12);
          lat_seen = 1;
        end
        if (out_ready) begin
          check({sb[0].tag, "_y"}, 32'(y), 32'(sb[0].y));
          check({sb[0].tag, "_flags"}, 32'(flags), 32'(sb[0].f));
          void'(sb.pop_front());
          lat_seen = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned prev;
    int unsigned c;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst = 1'b1;

    // Back-to-back vectors with the consumer always ready.
    prev = 0;
    for (int unsigned i = 0; i < 14; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].ey, vecs[i].ef, 1, $sformatf("v%0d", i));
      if (i > 0) check($sformatf("gap%0d", i), last_acc - prev, 32'd13);
      prev = last_acc;
    end
    wait_drain();

    // Backpressure: result must hold and a busy in_valid must be ignored.
    out_ready = 1'b0;
    send(16'hC0C0, 16'h4000, 16'hC040, 5'h00, 1, "hold");
    c = 0;
    while (!out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("hold_out_valid", 32'(out_valid), 32'd1);
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_y", 32'(y), 32'h0000C040);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      if (i == 5) begin
        x1 = 16'h3F80;
        x2 = 16'h3F80;
        in_valid = 1'b1;
      end
      if (i == 6) in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    repeat (20) @(negedge clk);
    check("no_extra_result", 32'(out_valid), 32'd0);

    // Reset in the middle of DIV abandons the operation.
    send(16'h40C0, 16'h4000, 16'h0000, 5'h00, 0, "abort");
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    send(16'h40C0, 16'h4000, 16'h4040, 5'h00, 1, "after_rst");
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fpdiv_param.md
Name: fpdiv_param

Overview:
Parametrised IEEE-style floating-point divider, successor to the fixed 16-bit (8-bit exponent, 7-bit mantissa) divider.
- Exponent and mantissa widths are generic.
- Uses valid/ready handshakes on input and output with backpressure.
- Applies round-to-nearest-even and full special-case handling (NaN, infinity, zero, overflow, underflow).
- Outputs exception flags.
- Sits between operand producer and result consumer in the arithmetic datapath; one operation in flight.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 7, stored fraction width (hidden bit excluded)
Derived (localparams, not overridable): W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
x1  in  W  dividend
x2  in  W  divisor
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
y  out  W  quotient
flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}, qualified by out_valid
out_valid  out  1  y/flags valid
out_ready  in  1  consumer accepts result

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE; in_ready=1; out_valid=0; y=0; flags=0; all internal registers cleared.
- Reset mid-operation abandons the operation; no result is produced.

FSM states: IDLE, DIV, NORM, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, capture x1/x2 and classify operands, then go to DIV.
- DIV: restoring divider, exactly MAN_W+3 cycles, one quotient bit per cycle. Then go to NORM.
- NORM: one cycle of normalise, round, special-case override; registers y/flags. Then go to OUT.
- OUT: out_valid=1. y/flags held stable until out_valid&out_ready, then go to IDLE.
- in_ready=1 only in IDLE. There is no same-cycle OUT-to-accept bypass.
- Latency: accept edge to out_valid high is MAN_W+5 cycles. The same latency applies to all cases, including special cases (the DIV result is discarded).
- Throughput: one result per MAN_W+6 cycles minimum.

Operand classes:
- exp==0 is zero; subnormals are flushed to zero and set no flag.
- exp all-ones with frac==0 is Inf.
- exp all-ones with frac!=0 is NaN.

Sign: s = x1.sign ^ x2.sign (not applied to NaN).

Divider:
- Dividend and divisor are {1,frac}, MAN_W+1 bits each.
- Quotient q has MAN_W+3 bits; q[MAN_W+2] has weight 2^0.

Exponent: e = ea - eb + BIAS, computed signed in EXP_W+2 bits.

Normalise:
- If q[MAN_W+2]=1: fraction = q[MAN_W+1:2], guard = q[1], sticky = q[0] | (rem!=0).
- Else: e = e-1, fraction = q[MAN_W:1], guard = q[0], sticky = (rem!=0).

Round to nearest even:
- Increment when guard & (sticky | fraction LSB).
- A fraction carry-out clears the fraction and sets e = e+1.
- inexact = guard | sticky.

Range:
- e >= 2^EXP_W-1 gives ±Inf, with overflow=1 and inexact=1.
- e <= 0 gives ±0, with underflow=1 and inexact=1.

Special-case priority (highest first):
1. Any NaN input gives canonical NaN; flags=0.
2. 0/0 or Inf/Inf gives canonical NaN; invalid=1.
3. Inf/x gives ±Inf.
4. x/0 (x finite, non-zero) gives ±Inf; div_by_zero=1.
5. 0/x or x/Inf gives ±0.

Canonical NaN: sign 0, exponent all-ones, fraction MSB=1, remaining fraction bits 0.

in_valid while busy: ignored; the producer must hold operands until in_ready.

Decomposition:
- Package fpdiv_pkg holds:
  - field-extract helper functions (sign, exp, frac)
  - the operand class enum (ZERO, NORM, INF, NAN)
  - FSM state enum
  - flag bit index constants
  - canonical-NaN builder function
- Sub-module mant_div_iter: restoring fractional divider with start/done, parametrised by N = MAN_W+1, producing MAN_W+3 quotient bits plus a remainder-nonzero output.
- Rounding stays inline in NORM.

Test Plan:
All cases use the defaults EXP_W=8, MAN_W=7.
- 6.0/2.0: x1=0x40C0, x2=0x4000 -> y=0x4040, flags=0, out_valid exactly 12 cycles after accept.
- 1.0/3.0: x1=0x3F80, x2=0x4040 -> y=0x3EAB (round-up by RNE), flags=00001.
- Special cases:
  - 0x3F80/0x0000 -> 0x7F80, flags=01000.
  - 0x0000/0x0000 -> 0x7FC0, flags=10000.
  - 0x7FC1/0x3F80 -> 0x7FC0, flags=0.
  - 0xBF80/0x7F80 -> 0x8000.
- Range limits:
  - 0x7F00/0x3E80 (2^127/2^-2) -> 0x7F80, flags=00101.
  - 0x0080/0x4000 (2^-126/2) -> 0x0000, flags=00011.
- Handshake and reset:
  - Hold out_ready=0 for 20 cycles: y stable, in_ready=0, and an in_valid pulse is not accepted.
  - Release out_ready: one-cycle handshake, then in_ready=1 next cycle.
  - Pull rst low mid-DIV: out_valid=0 and in_ready=1 immediately; no stale result afterwards.
